ofdm_symbol_buffer: RTL
=======================

# ofdm_symbol_buffer

- Receive-chain stage directly downstream of the cyclic-prefix remover. Collects the CP-stripped valid samples of each OFDM symbol into one bank of a ping-pong buffer.
- Replays every complete symbol to the FFT over a valid/ready stream, with first/last markers.
- Decouples the free-running, non-backpressurable sample stream from the FFT's input handshake, and flags symbols lost to overflow.

## Interface
- DATA_SIZE, 16, width of I and Q samples
- SYMBOLS_SIZE, 256, samples per symbol after CP removal; power of two, ≥4
- i_clk  in  1  clock
- i_reset  in  1  reset: synchronous, active-high, on i_clk
- i_valid  in  1  input sample strobe (no backpressure)
- in_data_i  in  DATA_SIZE  input I sample
- in_data_q  in  DATA_SIZE  input Q sample
- i_frame_sync  in  1  symbol realignment pulse; same pulse that drives the CP remover
- i_ready  in  1  FFT ready to accept an output sample
- out_valid  out  1  output sample valid
- out_data_i  out  DATA_SIZE  output I sample
- out_data_q  out  DATA_SIZE  output Q sample
- out_first  out  1  output sample is index 0 of a symbol
- out_last  out  1  output sample is index SYMBOLS_SIZE-1 of a symbol
- o_overflow  out  1  one-cycle pulse: an incoming symbol was discarded

## Operation
- **Storage:** two banks of SYMBOLS_SIZE complex words.
- **Write-side state:** wr_cnt (log2(SYMBOLS_SIZE) bits), wr_bank, per-bank full[1:0], drop flag.
- **Write, normal sample:** on i_valid and not i_frame_sync, write sample at address {wr_bank, wr_cnt}, then increment wr_cnt modulo SYMBOLS_SIZE.
  - On wr_cnt == SYMBOLS_SIZE-1: set full[wr_bank] and toggle wr_bank.
- **Overflow:** if i_valid arrives with wr_cnt == 0 and full[wr_bank] is set:
  - Set drop, pulse o_overflow.
  - wr_cnt still counts all SYMBOLS_SIZE samples, keeping alignment.
  - No writes occur, full is not set, wr_bank is not toggled.
  - drop clears at wrap.
- **i_frame_sync:** has priority over i_valid in the same cycle.
  - wr_cnt <= 0, drop <= 0, and any coincident sample is discarded.
  - The partial fill is abandoned. The full flags and the bank being read are untouched.
- **Read side:** rd_bank and rd_cnt.
  - When full[rd_bank] is set, issue memory reads through a 2-deep output pipeline/skid so that out_valid can stream at one sample per cycle.
  - out_first is high when the output index is 0; out_last is high when it is SYMBOLS_SIZE-1.
  - On the out_last handshake (out_valid && i_ready): clear full[rd_bank] and toggle rd_bank.
- **Free vs claim in the same cycle:** if the read side frees a bank in the same cycle the write side checks it for sample 0, the free wins. There is no overflow in that case.
- **Output data:** out_data_i/q are zero whenever out_valid is 0.

## Timing
- **Reset values:** all outputs 0. wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full=2'b00, drop=0. RAM contents are not cleared.
- **Latency:** out_valid rises 2 cycles after the edge that writes sample SYMBOLS_SIZE-1 (1-cycle RAM read + output register).
- **Handshake:** a transfer occurs on out_valid && i_ready.
  - While out_valid && !i_ready, out_data_*, out_first and out_last hold stable.
  - out_valid never drops mid-symbol except by reset.
- **Throughput:** with i_ready held high, one symbol streams out in SYMBOLS_SIZE consecutive cycles, and back-to-back symbols stream with no gap.
- **Reset mid-operation:** an in-flight output symbol is abandoned. Output resumes only after the next complete fill.

## Configuration
- OFDM_SYMBUF_BITREV_EN defined: the read address is the bit-reversed rd_cnt, so output is in bit-reversed order for a DIT FFT. out_first and out_last still mark the first and last transfers.
- Not defined: natural order.
- Latency and handshake are identical in both cases.

## Structure
- **Package ofdm_pkg:**
  - Default DATA_SIZE and SYMBOLS_SIZE.
  - clog2 constant for the address width.
  - bit_reverse function of the address width.
- **Sub-module ofdm_sdp_ram:**
  - Simple dual-port RAM, 2*SYMBOLS_SIZE deep, 2*DATA_SIZE wide.
  - Synchronous write, 1-cycle registered read.

## Test plan
- **Single symbol:** SYMBOLS_SIZE=8, i_ready=1, feed samples I=1..8 / Q=-1..-8 → out I=1..8 in order; out_first on I=1; out_last on I=8; first out_valid 2 cycles after the 8th write.
- **Backpressure:** toggle i_ready 1,0,0,1 repeatedly during readout → every sample delivered exactly once, data stable while stalled.
- **Overflow:** i_ready=0, feed 3 symbols → o_overflow pulses once on sample 0 of symbol 3. After raising i_ready, only symbols 1 and 2 are output.
- **Frame sync:** i_frame_sync after 5 of 8 samples, then 8 new samples → only the 8 new samples are output. A sample coincident with the sync is not stored.
- **Reset mid-readout:** i_reset after 3 output samples → all outputs 0 next cycle; the next full symbol is output from index 0.
- **Bit reverse:** OFDM_SYMBUF_BITREV_EN defined, samples 0..7 → output order 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared defaults, tags and address helpers for the OFDM symbol buffer.
// Bit-reversed readout is selected with the OFDM_SYMBUF_BITREV_EN macro.
package ofdm_pkg;

  localparam int DATA_SIZE_DEF    = 16;
  localparam int SYMBOLS_SIZE_DEF = 256;
  localparam int ADDR_W_DEF       = $clog2(SYMBOLS_SIZE_DEF);
  localparam int MAX_ADDR_W       = 16;

  // Position markers that travel alongside each sample through the read pipeline.
  typedef struct packed {
    logic first;
    logic last;
  } beat_tag_t;

  // Reverses the low 'width' bits of 'a'; bits above 'width' come back as zero.
  function automatic logic [MAX_ADDR_W-1:0] bit_reverse(input logic [MAX_ADDR_W-1:0] a,
                                                        input int width);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_ADDR_W; k++) begin
      if (k < width) r[k] = a[width-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofdm_sdp_ram.sv
// Simple dual-port RAM holding both symbol banks: synchronous write, registered read.
module ofdm_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and read register carry no reset so they map onto block RAM;
  // stale contents are harmless because the bank flags gate every read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ofdm_symbol_buffer.sv
// Ping-pong symbol buffer between the CP remover and the FFT with valid/ready replay.
// Define OFDM_SYMBUF_BITREV_EN to replay each symbol in bit-reversed address order.
module ofdm_symbol_buffer
  import ofdm_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int SYMBOLS_SIZE = SYMBOLS_SIZE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  input  logic                 i_frame_sync,
  input  logic                 i_ready,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 o_overflow
);

  localparam int              AW       = $clog2(SYMBOLS_SIZE);
  localparam int              WW       = 2 * DATA_SIZE;
  localparam logic [AW-1:0]   LAST_IDX = AW'(SYMBOLS_SIZE - 1);

  // Write side
  logic [AW-1:0] wr_cnt;
  logic          wr_bank;
  logic [1:0]    full;
  logic          drop;

  // Read side: iss_bank/rd_cnt drive the RAM, rd_bank is the bank on the output
  logic          rd_bank;
  logic          iss_bank;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] rd_addr_lo;

  logic          ram_valid;
  beat_tag_t     ram_tag;
  logic [WW-1:0] ram_rdata;
  logic          skid_valid;
  beat_tag_t     skid_tag;
  logic [WW-1:0] skid_word;
  beat_tag_t     out_tag;
  logic [WW-1:0] out_word;

  logic          free_evt;
  logic [1:0]    free_mask;
  logic [1:0]    set_mask;
  logic [1:0]    full_avail;
  logic          smp;
  logic          ovf_hit;
  logic          drop_now;
  logic          wr_en;
  logic          out_ready;
  logic          skid_next;
  logic          rd_en;

  // A bank released by the reader this cycle is already available to the writer.
  assign free_evt   = out_valid && i_ready && out_tag.last;
  assign full_avail = full & ~free_mask;
  assign smp        = i_valid && !i_frame_sync;
  assign ovf_hit    = smp && (wr_cnt == '0) && full_avail[wr_bank];
  assign drop_now   = drop || ovf_hit;
  assign wr_en      = smp && !drop_now;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    free_mask = 2'b00;
    set_mask  = 2'b00;
    if (free_evt) free_mask[rd_bank] = 1'b1;
    if (wr_en && (wr_cnt == LAST_IDX)) set_mask[wr_bank] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      full       <= 2'b00;
      drop       <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= ovf_hit;
      full       <= full_avail | set_mask;
      if (i_frame_sync) begin
        wr_cnt <= '0;
        drop   <= 1'b0;
      end else if (i_valid) begin
        wr_cnt <= wr_cnt + AW'(1);
        if (wr_cnt == LAST_IDX) begin
          drop <= 1'b0;
          if (!drop_now) wr_bank <= ~wr_bank;
        end else if (ovf_hit) begin
          drop <= 1'b1;
        end
      end
    end
  end

  // Issue a read only when its data is guaranteed a slot (output or skid) next cycle.
  assign out_ready = !out_valid || i_ready;
  assign skid_next = (skid_valid && !out_ready) || (ram_valid && (skid_valid || !out_ready));
  assign rd_en     = full[iss_bank] && !skid_next;

`ifdef OFDM_SYMBUF_BITREV_EN
  assign rd_addr_lo = AW'(bit_reverse(MAX_ADDR_W'(rd_cnt), AW));
`else
  assign rd_addr_lo = rd_cnt;
`endif

  ofdm_sdp_ram #(
    .WIDTH (WW),
    .DEPTH (2 * SYMBOLS_SIZE)
  ) u_ram (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data ({in_data_i, in_data_q}),
    .rd_en   (rd_en),
    .rd_addr ({iss_bank, rd_addr_lo}),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_bank    <= 1'b0;
      iss_bank   <= 1'b0;
      rd_cnt     <= '0;
      ram_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      ram_valid <= rd_en;
      if (rd_en) begin
        rd_cnt <= rd_cnt + AW'(1);
        if (rd_cnt == LAST_IDX) iss_bank <= ~iss_bank;
      end
      if (free_evt) rd_bank <= ~rd_bank;
      if (out_ready) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          skid_valid <= ram_valid;
        end else begin
          out_valid  <= ram_valid;
        end
      end else if (ram_valid) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // Payload registers follow the valid bits above and need no reset.
  always_ff @(posedge i_clk) begin
    if (rd_en) ram_tag <= '{first: (rd_cnt == '0), last: (rd_cnt == LAST_IDX)};
    if (out_ready) begin
      if (skid_valid) begin
        out_word  <= skid_word;
        out_tag   <= skid_tag;
        skid_word <= ram_rdata;
        skid_tag  <= ram_tag;
      end else if (ram_valid) begin
        out_word <= ram_rdata;
        out_tag  <= ram_tag;
      end
    end else if (ram_valid) begin
      skid_word <= ram_rdata;
      skid_tag  <= ram_tag;
    end
  end

  assign out_data_i = out_valid ? out_word[WW-1:DATA_SIZE] : '0;
  assign out_data_q = out_valid ? out_word[DATA_SIZE-1:0]  : '0;
  assign out_first  = out_valid && out_tag.first;
  assign out_last   = out_valid && out_tag.last;

endmodule
